// File: rtl/lcd_frame_scheduler.sv
// Streams the framebuffer to the panel page by page over the shared I2C byte
// transmitter: three address commands per page, then 128 column data bytes.
module lcd_frame_scheduler #(
  parameter int unsigned COL_OFFSET = 0,
  parameter logic [7:0]  CMD_CTRL   = 8'h00,
  parameter logic [7:0]  DATA_CTRL  = 8'h40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_req,
  output logic [9:0] fb_addr,
  input  logic [7:0] fb_rdata,
  output logic [7:0] reg_addr,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_done,
  output logic       busy,
  output logic       frame_done
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FETCH, S_LOAD} state_e;
  typedef enum logic [1:0] {PH_PAGE, PH_COLH, PH_COLL, PH_DATA} phase_e;

  localparam logic [7:0] COL_OFF  = 8'(COL_OFFSET);
  localparam logic [7:0] PAGE_CMD = 8'hB0;
  localparam logic [7:0] COLH_CMD = 8'h10 | {4'h0, COL_OFF[7:4]};
  localparam logic [7:0] COLL_CMD = {4'h0, COL_OFF[3:0]};

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  logic [2:0] page_q, page_d;
  logic [6:0] col_q, col_d;
  logic       pending_q, pending_d;
  logic [9:0] fb_addr_q, fb_addr_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       frame_done_q, frame_done_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    phase_d      = phase_q;
    page_d       = page_q;
    col_d        = col_q;
    pending_d    = pending_q;
    fb_addr_d    = fb_addr_q;
    reg_addr_d   = reg_addr_q;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;

    // One request can be parked while a frame is running; extras are dropped.
    if (frame_req && enable && state_q != S_IDLE) pending_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (enable && (frame_req || pending_q)) begin
          pending_d  = 1'b0;
          page_d     = '0;
          col_d      = '0;
          phase_d    = PH_PAGE;
          reg_addr_d = CMD_CTRL;
          tx_data_d  = PAGE_CMD;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          unique case (phase_q)
            PH_PAGE: begin
              phase_d    = PH_COLH;
              reg_addr_d = CMD_CTRL;
              tx_data_d  = COLH_CMD;
              state_d    = S_ISSUE;
            end
            PH_COLH: begin
              phase_d    = PH_COLL;
              reg_addr_d = CMD_CTRL;
              tx_data_d  = COLL_CMD;
              state_d    = S_ISSUE;
            end
            PH_COLL: begin
              phase_d   = PH_DATA;
              fb_addr_d = {page_q, col_q};
              state_d   = S_FETCH;
            end
            PH_DATA: begin
              if (col_q != 7'd127) begin
                col_d     = col_q + 7'd1;
                fb_addr_d = {page_q, col_d};
                state_d   = S_FETCH;
              end else if (page_q != 3'd7) begin
                page_d     = page_q + 3'd1;
                col_d      = '0;
                phase_d    = PH_PAGE;
                reg_addr_d = CMD_CTRL;
                tx_data_d  = PAGE_CMD | {5'b0, page_d};
                state_d    = S_ISSUE;
              end else begin
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      // The RAM word for fb_addr is on fb_rdata during LOAD.
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        reg_addr_d = DATA_CTRL;
        tx_data_d  = fb_rdata;
        state_d    = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the values from before this edge, independent of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_PAGE;
      page_q       <= '0;
      col_q        <= '0;
      pending_q    <= 1'b0;
      fb_addr_q    <= '0;
      reg_addr_q   <= '0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      page_q       <= page_d;
      col_q        <= col_d;
      pending_q    <= pending_d;
      fb_addr_q    <= fb_addr_d;
      reg_addr_q   <= reg_addr_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fb_addr    = fb_addr_q;
  assign reg_addr   = reg_addr_q;
  assign tx_data    = tx_data_q;
  assign tx_en      = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Bench for lcd_frame_scheduler: a default instance and a COL_OFFSET=4 instance,
// each with a RAM model, a transmitter responder and a byte-stream scoreboard.
module tb_lcd_frame_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       frame_req = 1'b0;

  logic [9:0] fb_addr, fb_addr4;
  logic [7:0] fb_rdata = 8'h00, fb_rdata4 = 8'h00;
  logic [7:0] reg_addr, tx_data, reg_addr4, tx_data4;
  logic       tx_en, tx_en4, busy, busy4, frame_done, frame_done4;
  logic       tx_done, tx_done4;
  logic       resp_done = 1'b0, resp_done4 = 1'b0, extra_done = 1'b0;

  assign tx_done  = resp_done | extra_done;
  assign tx_done4 = resp_done4;

  lcd_frame_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_req(frame_req),
    .fb_addr(fb_addr), .fb_rdata(fb_rdata), .reg_addr(reg_addr),
    .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done),
    .busy(busy), .frame_done(frame_done)
  );

  lcd_frame_scheduler #(.COL_OFFSET(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .frame_req(frame_req),
    .fb_addr(fb_addr4), .fb_rdata(fb_rdata4), .reg_addr(reg_addr4),
    .tx_data(tx_data4), .tx_en(tx_en4), .tx_done(tx_done4),
    .busy(busy4), .frame_done(frame_done4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Framebuffer contents shared by both synchronous RAM models.
  logic [7:0] mem [1024];
  always @(posedge clk) begin
    fb_rdata  <= mem[fb_addr];
    fb_rdata4 <= mem[fb_addr4];
  end

  // Reference byte stream: 131 bytes per page, three commands then 128 columns.
  function automatic logic [15:0] exp_byte(input int idx, input logic [7:0] off);
    int pg, k;
    logic [9:0] a;
    pg = idx / 131;
    k  = idx % 131;
    if (k == 0) return {8'h00, 8'hB0 | 8'(pg)};
    if (k == 1) return {8'h00, 8'h10 | {4'h0, off[7:4]}};
    if (k == 2) return {8'h00, {4'h0, off[3:0]}};
    a = {3'(pg), 7'(k - 3)};
    return {8'h40, mem[a]};
  endfunction

  // Transmitter responders: tx_done pulses lat cycles after the WAIT begins.
  int lat = 1;
  bit rand_lat = 1'b0;
  int cnt = -1, cnt4 = -1;
  always @(negedge clk) begin
    resp_done = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin resp_done = 1'b1; cnt = -1; end
    end
    if (tx_en) cnt = rand_lat ? int'($urandom_range(3, 1)) : lat;
    resp_done4 = 1'b0;
    if (cnt4 > 0) begin
      cnt4--;
      if (cnt4 == 0) begin resp_done4 = 1'b1; cnt4 = -1; end
    end
    if (tx_en4) cnt4 = 1;
  end

  // Scoreboards, sampled just after each active edge.
  int idx = 0, idx4 = 0;
  logic [15:0] log_main [1048];
  logic [15:0] log4 [1048];
  logic [15:0] held;
  bit outstanding = 1'b0;
  int stab_viol = 0;
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      idx = 0; idx4 = 0; outstanding = 1'b0;
    end else begin
      if (outstanding && tx_done) outstanding = 1'b0;
      else if (outstanding && {reg_addr, tx_data} !== held) stab_viol++;
      if (tx_en) begin
        if (idx < 1048) begin
          check($sformatf("byte%0d", idx), 32'({reg_addr, tx_data}), 32'(exp_byte(idx, 8'h00)));
          log_main[idx] = {reg_addr, tx_data};
        end else check("frame_overrun", idx, 1047);
        idx++;
        held = {reg_addr, tx_data};
        outstanding = 1'b1;
      end
      if (frame_done) begin check("frame_len", idx, 1048); idx = 0; end
      if (tx_en4) begin
        if (idx4 < 1048) begin
          check($sformatf("off4_byte%0d", idx4), 32'({reg_addr4, tx_data4}), 32'(exp_byte(idx4, 8'h04)));
          log4[idx4] = {reg_addr4, tx_data4};
        end else check("off4_frame_overrun", idx4, 1047);
        idx4++;
      end
      if (frame_done4) begin check("off4_frame_len", idx4, 1048); idx4 = 0; end
    end
  end

  typedef struct packed {
    logic       rst, en, req;
    logic       tx_en, busy, fd;
    logic [7:0] data, reg_a;
  } vec_t;
  vec_t vecs [11];

  int  n_en, n_fd, fd_cyc, fd1, fd2, en_after_fd1, idle_run, rand_fd;
  bit  fd_busy, seen_en, seen_busy, hit;

  initial begin
    //          rst en req  tx_en busy fd  tx_data reg_addr
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hB0, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB0, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;

    // Reset values, then a request with enable low.
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_en", 32'(tx_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_reg_addr", 32'(reg_addr), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    @(negedge clk); rst = 1'b0; frame_req = 1'b1;
    @(negedge clk); frame_req = 1'b0;
    seen_en = 1'b0; seen_busy = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      seen_en |= tx_en; seen_busy |= busy;
    end
    check("disabled_tx_en", 32'(seen_en), 0);
    check("disabled_busy", 32'(seen_busy), 0);

    // Cycle-by-cycle vector table: start, enable drop, pending cleared by reset.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; enable = vecs[i].en; frame_req = vecs[i].req;
      @(posedge clk); #1;
      check($sformatf("vec%0d_tx_en", i), 32'(tx_en), 32'(vecs[i].tx_en));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_frame_done", i), 32'(frame_done), 32'(vecs[i].fd));
      check($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].data));
      check($sformatf("vec%0d_reg_addr", i), 32'(reg_addr), 32'(vecs[i].reg_a));
    end

    // Single frame with a one-cycle responder.
    @(negedge clk); enable = 1'b1; frame_req = 1'b1;
    @(posedge clk); #1;
    check("c1_tx_en", 32'(tx_en), 1);
    check("c1_tx_data", 32'(tx_data), 32'h B0);
    check("c1_busy", 32'(busy), 1);
    @(negedge clk); frame_req = 1'b0;
    n_en = 1; fd_cyc = 0; fd_busy = 1'b1;
    for (int c = 2; c <= 6000 && fd_cyc == 0; c++) begin
      @(posedge clk); #1;
      if (tx_en) n_en++;
      if (frame_done) begin fd_cyc = c; fd_busy = busy; end
    end
    check("frame_tx_en_count", n_en, 1048);
    check("frame_done_cycle", fd_cyc, 4145);
    check("frame_done_busy", 32'(fd_busy), 0);
    check("p3_page_cmd", 32'(log_main[393]), 32'h 00B3);
    check("p3_colh_cmd", 32'(log_main[394]), 32'h 0010);
    check("p3_coll_cmd", 32'(log_main[395]), 32'h 0000);
    check("p3_c5_data", 32'(log_main[401]), 32'({8'h40, 8'h85 ^ 8'h5A}));
    for (int p = 0; p < 8; p++) begin
      check($sformatf("off4_p%0d_colh", p), 32'(log4[p * 131 + 1]), 32'h 0010);
      check($sformatf("off4_p%0d_coll", p), 32'(log4[p * 131 + 2]), 32'h 0004);
    end

    // Slow transmitter, then stray tx_done pulses while idle.
    lat = 37;
    @(negedge clk); frame_req = 1'b1;
    @(negedge clk); frame_req = 1'b0;
    fd_cyc = 0;
    for (int c = 0; c < 50000 && fd_cyc == 0; c++) begin
      @(posedge clk); #1;
      if (frame_done) fd_cyc = c + 1;
    end
    check("slow_frame_done", 32'(fd_cyc != 0), 1);
    check("slow_stability", stab_viol, 0);
    lat = 1;
    repeat (5) @(negedge clk);
    seen_en = 1'b0; seen_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); extra_done = (i % 7 == 0);
      @(posedge clk); #1;
      seen_en |= tx_en; seen_busy |= busy;
    end
    @(negedge clk); extra_done = 1'b0;
    check("stray_done_tx_en", 32'(seen_en), 0);
    check("stray_done_busy", 32'(seen_busy), 0);

    // Request queueing: three extra requests during the first frame.
    n_fd = 0; fd1 = 0; fd2 = 0; n_en = 0; en_after_fd1 = 0;
    for (int c = 0; c < 9000; c++) begin
      if (c != 0) @(negedge clk);
      frame_req = (c == 0 || c == 100 || c == 2000 || c == 3000);
      @(posedge clk); #1;
      if (tx_en) begin
        n_en++;
        if (n_fd == 1 && en_after_fd1 == 0) en_after_fd1 = c + 1;
      end
      if (frame_done) begin
        n_fd++;
        if (n_fd == 1) fd1 = c + 1;
        else if (n_fd == 2) fd2 = c + 1;
      end
      if (n_fd >= 2 && c + 1 >= fd2 + 200) break;
    end
    @(negedge clk); frame_req = 1'b0;
    check("queue_frame_done_count", n_fd, 2);
    check("queue_fd1_cycle", fd1, 4145);
    check("queue_restart_cycle", en_after_fd1, fd1 + 1);
    check("queue_fd2_cycle", fd2, fd1 + 4145);
    check("queue_tx_en_count", n_en, 2096);

    // Reset in the middle of page 2, column 40, with a request pending.
    n_en = 0; hit = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      if (c != 0) @(negedge clk);
      frame_req = (c == 0 || c == 50);
      @(posedge clk); #1;
      if (tx_en) begin
        n_en++;
        if (n_en == 306) hit = 1'b1;
      end
    end
    check("mid_reached", 32'(hit), 1);
    check("mid_byte", 32'({reg_addr, tx_data}), 32'h 4072);
    @(negedge clk); frame_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_tx_en", 32'(tx_en), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_tx_data", 32'(tx_data), 0);
    check("mid_rst_reg_addr", 32'(reg_addr), 0);
    check("mid_rst_fb_addr", 32'(fb_addr), 0);
    @(negedge clk); rst = 1'b0;
    seen_en = 1'b0; seen_busy = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      seen_en |= tx_en; seen_busy |= busy;
    end
    check("mid_pending_cleared", 32'(seen_en | seen_busy), 0);
    @(negedge clk); frame_req = 1'b1;
    @(posedge clk); #1;
    check("restart_tx_en", 32'(tx_en), 1);
    check("restart_tx_data", 32'(tx_data), 32'h B0);
    check("restart_reg_addr", 32'(reg_addr), 0);
    @(negedge clk); frame_req = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // Randomised traffic: random RAM, responder latency, requests and enable.
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    rand_lat = 1'b1;
    rand_fd = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      frame_req = (c == 0) || ($urandom_range(1500, 0) == 0);
      if (c != 0 && $urandom_range(200, 0) == 0) enable = ~enable;
      @(posedge clk); #1;
      if (frame_done) rand_fd++;
    end
    @(negedge clk); frame_req = 1'b0; enable = 1'b1;
    idle_run = 0;
    for (int c = 0; c < 20000 && idle_run < 3; c++) begin
      @(posedge clk); #1;
      if (frame_done) rand_fd++;
      idle_run = (busy || busy4) ? 0 : idle_run + 1;
    end
    check("rand_drained", 32'(idle_run >= 3), 1);
    check("rand_frames_seen", 32'(rand_fd > 0), 1);
    check("final_stability", stab_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
